uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 112 +++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, ready flag with consumer acknowledge.
// Optional stop-bit checking and the frame_err port are enabled by defining UART_RX_FRAME_CHK_EN.
module uart_rx #(
    parameter int unsigned HALF_BIT = 1302,
    parameter int unsigned FULL_BIT = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
`ifdef UART_RX_FRAME_CHK_EN
    output logic       frame_err,
`endif
    output logic       rdy
);

    typedef enum logic {
        IDLE,
        RECEIVE
    } state_t;

    localparam logic [11:0] HALF_LOAD = 12'(HALF_BIT);
    localparam logic [11:0] FULL_LOAD = 12'(FULL_BIT);
    localparam logic [3:0]  LAST_BIT  = 4'd10;

    state_t      state_reg;
    logic        rx_meta_reg;
    logic        rx_sync;
    logic [11:0] baud_cnt;
    logic [8:0]  sr;
    logic [3:0]  bit_cnt;
    logic        start_strobe;
    logic        shift;
    logic        set_rdy;
    logic        stop_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_sync     <= 1'b1;
        end else begin
            rx_meta_reg <= RX;
            rx_sync     <= rx_meta_reg;
        end
    end

    assign start_strobe = (state_reg == IDLE) && !rx_sync;
    assign set_rdy      = (state_reg == RECEIVE) && (bit_cnt == LAST_BIT);
    assign shift        = (state_reg == RECEIVE) && (bit_cnt != LAST_BIT) && (baud_cnt == 12'd0);
    assign rx_data      = sr[7:0];

`ifdef UART_RX_FRAME_CHK_EN
    assign stop_ok = sr[8];
`else
    assign stop_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            baud_cnt  <= 12'd0;
            bit_cnt   <= 4'd0;
            sr        <= 9'h1FF;
            rdy       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_strobe) begin
                        // First wait is half a bit so every sample lands mid-bit
                        state_reg <= RECEIVE;
                        baud_cnt  <= HALF_LOAD;
                        bit_cnt   <= 4'd0;
                        sr        <= 9'h1FF;
                    end
                end
                RECEIVE: begin
                    if (set_rdy) begin
                        state_reg <= IDLE;
                    end else if (shift) begin
                        sr       <= {rx_sync, sr[8:1]};
                        baud_cnt <= FULL_LOAD;
                        bit_cnt  <= bit_cnt + 4'd1;
                    end else begin
                        baud_cnt <= baud_cnt - 12'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // A completed frame outranks any coincident acknowledge
            if (set_rdy && stop_ok) begin
                rdy <= 1'b1;
            end else if (clr_rdy || start_strobe) begin
                rdy <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FRAME_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else if (set_rdy && !sr[8]) begin
            frame_err <= 1'b1;
        end else if (clr_rdy || start_strobe) begin
            frame_err <= 1'b0;
        end
    end
`endif

endmodule
